// File: rtl/mypackage.sv
// rtl/mypackage.sv - shared types and constants for the key conditioner
package mypackage;

    localparam int FREQUENCY_WIDTH           = 32;
    localparam int FREQUENCY_FRACTIONAL_BITS = 16;

    typedef logic [FREQUENCY_WIDTH-1:0] frequency;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_t;

    // 32-bit word with 16 fractional bits leaves headroom for 2*20000 Hz.
    function automatic frequency note_freq(input int base_hz, input logic octave);
        frequency f;
        f = frequency'(base_hz);
        if (octave) begin
            f = f << 1;
        end
        return f << FREQUENCY_FRACTIONAL_BITS;
    endfunction

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - single-key synchroniser, debounce counter and press/release FSM
module debounce
    import mypackage::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level;
    key_state_t             state;
    key_state_t             state_next;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic                   press_evt;
    logic                   release_evt;

    // Reset to all-ones so a held button is not seen as pressed straight out of reset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
        end
    end

    assign level = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state         <= RELEASED;
            count         <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            press_pulse   <= press_evt;
            release_pulse <= release_evt;
            if (press_evt) begin
                pressed <= 1'b1;
            end else if (release_evt) begin
                pressed <= 1'b0;
            end
        end
    end

    // The counter leaves the wait state as soon as it hits CNT_LAST, so it never wraps.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            RELEASED: begin
                if (level) begin
                    state_next = PRESS_WAIT;
                    count_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!level) begin
                    state_next = RELEASED;
                    count_next = '0;
                end else if (count == CNT_LAST) begin
                    state_next = HELD;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            HELD: begin
                if (!level) begin
                    state_next = RELEASE_WAIT;
                    count_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (level) begin
                    state_next = HELD;
                    count_next = '0;
                end else if (count == CNT_LAST) begin
                    state_next = RELEASED;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = RELEASED;
                count_next = '0;
            end
        endcase
    end

    always_comb begin
        press_evt   = 1'b0;
        release_evt = 1'b0;
        if (state == PRESS_WAIT && level && count == CNT_LAST) begin
            press_evt = 1'b1;
        end
        if (state == RELEASE_WAIT && !level && count == CNT_LAST) begin
            release_evt = 1'b1;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced push-buttons to note gate and NCO frequency word
module key_conditioner
    import mypackage::*;
#(
    parameter int NKEYS           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int GATE_KEY        = 0,
    parameter int OCTAVE_KEY      = 1,
    parameter int BASE_HZ         = 440
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [NKEYS-1:0]           key_n,
    output logic [NKEYS-1:0]           pressed,
    output logic [NKEYS-1:0]           press_pulse,
    output logic [NKEYS-1:0]           release_pulse,
    output logic                       gate,
    output logic [FREQUENCY_WIDTH-1:0] freq
);

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .CLOCK_50     (CLOCK_50),
            .reset        (reset),
            .key_n        (key_n[i]),
            .pressed      (pressed[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i])
        );
    end

    assign gate = pressed[GATE_KEY];

    // Registered so the audio domain sees a single clean transition per note change.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            freq <= '0;
        end else begin
            freq <= note_freq(BASE_HZ, pressed[OCTAVE_KEY]);
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - randomized self-checking bench for key_conditioner
module tb_key_conditioner;

    localparam int NKEYS = 2;
    localparam int SYNC  = 2;
    localparam int DEB   = 8;
    localparam int BASE  = 440;
    localparam int FRAC  = 16;
    localparam logic [31:0] F_LO = 32'(BASE * (1 << FRAC));
    localparam logic [31:0] F_HI = 32'(2 * BASE * (1 << FRAC));

    logic             CLOCK_50 = 1'b0;
    logic             reset;
    logic [NKEYS-1:0] key_n;
    logic [NKEYS-1:0] pressed;
    logic [NKEYS-1:0] press_pulse;
    logic [NKEYS-1:0] release_pulse;
    logic             gate;
    logic [31:0]      freq;

    int checks = 0;
    int passed = 0;

    key_conditioner #(
        .NKEYS          (NKEYS),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .GATE_KEY       (0),
        .OCTAVE_KEY     (1),
        .BASE_HZ        (BASE)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .key_n        (key_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .gate         (gate),
        .freq         (freq)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference: a level is accepted once the synchronised input has disagreed with
    // the current debounced level for DEB+1 consecutive clock samples.
    logic [NKEYS-1:0] m_s1, m_s2, m_pressed, m_pp, m_rp;
    logic [31:0]      m_freq;
    int               run [NKEYS];

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            m_s1 = '1; m_s2 = '1; m_pressed = '0; m_pp = '0; m_rp = '0; m_freq = '0;
            for (int k = 0; k < NKEYS; k++) run[k] = 0;
        end else begin
            m_freq = 32'(BASE * (m_pressed[1] ? 2 : 1) * (1 << FRAC));
            for (int k = 0; k < NKEYS; k++) begin
                logic l;
                l = !m_s2[k];
                m_pp[k] = 1'b0;
                m_rp[k] = 1'b0;
                if (l != m_pressed[k]) begin
                    run[k]++;
                    if (run[k] == DEB + 1) begin
                        m_pressed[k] = l;
                        m_pp[k] = l;
                        m_rp[k] = !l;
                        run[k] = 0;
                    end
                end else begin
                    run[k] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = key_n;
        end
    end

    logic [38:0] obs_vec, exp_vec;
    assign obs_vec = {pressed, press_pulse, release_pulse, gate, freq};
    assign exp_vec = {m_pressed, m_pp, m_rp, m_pressed[0], m_freq};

    task automatic test_reset();
        key_n = '1;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) begin
            @(negedge CLOCK_50);
            checks++;
            if (obs_vec !== 39'd0) $display("FAIL reset_outputs got %h want 0", obs_vec);
            else passed++;
        end
        reset = 1'b0;
        @(negedge CLOCK_50);
        checks++;
        if (freq !== F_LO) $display("FAIL reset_first_freq got %h want %h", freq, F_LO);
        else passed++;
        checks++;
        if (obs_vec !== exp_vec) $display("FAIL reset_model got %h want %h", obs_vec, exp_vec);
        else passed++;
    endtask

    task automatic test_press();
        int lat = -1;
        int pulses = 0;
        int bad = 0;
        key_n[0] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLOCK_50);
            if (obs_vec !== exp_vec) bad++;
            if (press_pulse[0]) pulses++;
            if (pressed[0] && lat < 0) begin
                lat = n;
                checks++;
                if (!(press_pulse[0] && gate)) $display("FAIL press_edge pulse=%b gate=%b want 1 1", press_pulse[0], gate);
                else passed++;
            end
        end
        checks++;
        if (lat < SYNC + DEB - 1 || lat > SYNC + DEB + 1) $display("FAIL press_latency got %0d want %0d..%0d", lat, SYNC + DEB - 1, SYNC + DEB + 1);
        else passed++;
        checks++;
        if (pulses != 1) $display("FAIL press_pulse_count got %0d want 1", pulses);
        else passed++;
        key_n[0] = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge CLOCK_50);
            if (obs_vec !== exp_vec) bad++;
        end
        checks++;
        if (bad != 0 || pressed[0] !== 1'b0) $display("FAIL press_model got %0d mismatching cycles pressed=%b want 0 0", bad, pressed[0]);
        else passed++;
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int at = -1;
        int bad = 0;
        for (int n = 0; n < 30; n++) begin
            key_n[0] = (n >= 5 && n < 7) ? 1'b1 : 1'b0;
            @(negedge CLOCK_50);
            if (obs_vec !== exp_vec) bad++;
            if (press_pulse[0]) begin
                pulses++;
                at = n + 1;
            end
        end
        checks++;
        if (pulses != 1) $display("FAIL bounce_pulse_count got %0d want 1", pulses);
        else passed++;
        checks++;
        if (at < 7 + SYNC + DEB - 1 || at > 7 + SYNC + DEB + 1) $display("FAIL bounce_pulse_time got %0d want %0d..%0d", at, 7 + SYNC + DEB - 1, 7 + SYNC + DEB + 1);
        else passed++;
        key_n[0] = 1'b1;
        repeat (16) begin
            @(negedge CLOCK_50);
            if (obs_vec !== exp_vec) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL bounce_model got %0d mismatching cycles want 0", bad);
        else passed++;
    endtask

    task automatic test_octave();
        int seen = 0;
        int bad = 0;
        logic prev_p = 1'b0;
        logic prev_r = 1'b0;
        key_n[1] = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLOCK_50);
            if (obs_vec !== exp_vec) bad++;
            if (pressed[1] && !prev_p) begin
                checks++;
                if (freq !== F_LO) $display("FAIL octave_freq_lag got %h want %h", freq, F_LO);
                else passed++;
            end
            if (prev_p && pressed[1] && seen == 0) begin
                seen = 1;
                checks++;
                if (freq !== F_HI) $display("FAIL octave_freq_high got %h want %h", freq, F_HI);
                else passed++;
            end
            prev_p = pressed[1];
        end
        key_n[1] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLOCK_50);
            if (obs_vec !== exp_vec) bad++;
            if (prev_r) begin
                seen++;
                checks++;
                if (freq !== F_LO) $display("FAIL octave_freq_low got %h want %h", freq, F_LO);
                else passed++;
            end
            prev_r = release_pulse[1];
        end
        checks++;
        if (seen != 2 || bad != 0) $display("FAIL octave_events got %0d events %0d bad want 2 0", seen, bad);
        else passed++;
    endtask

    task automatic test_both();
        int both = 0;
        int single = 0;
        key_n = 2'b00;
        repeat (20) begin
            @(negedge CLOCK_50);
            if (press_pulse == 2'b11) both++;
            else if (press_pulse != 2'b00) single++;
        end
        checks++;
        if (both != 1 || single != 0) $display("FAIL both_pulses got both=%0d single=%0d want 1 0", both, single);
        else passed++;
        key_n = 2'b11;
        repeat (16) @(negedge CLOCK_50);
        checks++;
        if (obs_vec !== exp_vec) $display("FAIL both_release got %h want %h", obs_vec, exp_vec);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int bad = 0;
        key_n[0] = 1'b0;
        repeat (SYNC + 1 + 4) @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (3) begin
            @(negedge CLOCK_50);
            checks++;
            if (pressed !== 2'b00 || press_pulse !== 2'b00) $display("FAIL reset_mid_abort got pressed=%b pulse=%b want 00 00", pressed, press_pulse);
            else passed++;
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge CLOCK_50);
            if (obs_vec !== exp_vec) bad++;
            if (press_pulse[0]) pulses++;
        end
        checks++;
        if (pulses != 1 || pressed[0] !== 1'b1 || bad != 0) $display("FAIL reset_mid_resume got pulses=%0d pressed=%b bad=%0d want 1 1 0", pulses, pressed[0], bad);
        else passed++;
        key_n[0] = 1'b1;
        repeat (16) @(negedge CLOCK_50);
    endtask

    task automatic test_random();
        int bad = 0;
        int cyc = 0;
        for (int seg = 0; seg < 60; seg++) begin
            key_n = NKEYS'($urandom_range(0, 3));
            repeat ($urandom_range(1, 14)) begin
                @(negedge CLOCK_50);
                cyc++;
                if (obs_vec !== exp_vec) begin
                    bad++;
                    if (bad <= 3) $display("FAIL random_model cycle %0d got %h want %h", cyc, obs_vec, exp_vec);
                end
            end
        end
        checks++;
        if (bad != 0) $display("FAIL random_total got %0d mismatching cycles want 0", bad);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_octave();
        test_both();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
